// File: rtl/alu_pkg.sv
// ALU op codes, datapath widths and the ID/EX operand bundle.
// Shared by the operand stage and its skid buffer.
package alu_pkg;

  localparam int ALU_XLEN = 32;
  localparam int ALU_RIDX = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBU = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_NOR  = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;

  typedef struct packed {
    logic [ALU_XLEN-1:0] a;
    logic [ALU_XLEN-1:0] b;
    logic                cin;
    logic [3:0]          op;
    logic [ALU_RIDX-1:0] rd;
    logic                ovf_trap;
  } opnd_t;

  // x0 never forwards; EX/MEM wins over MEM/WB.
  function automatic logic [ALU_XLEN-1:0] fwd_sel(
    input logic [ALU_RIDX-1:0] idx,
    input logic [ALU_XLEN-1:0] rf,
    input logic                ew,
    input logic [ALU_RIDX-1:0] ei,
    input logic [ALU_XLEN-1:0] ed,
    input logic                mw,
    input logic [ALU_RIDX-1:0] mi,
    input logic [ALU_XLEN-1:0] md
  );
    logic [ALU_XLEN-1:0] v;
    if (idx == '0)
      v = '0;
    else if (ew && ei == idx)
      v = ed;
    else if (mw && mi == idx)
      v = md;
    else
      v = rf;
    return v;
  endfunction

endpackage

// File: rtl/alu_operand_stage_skid.sv
// Two-entry skid buffer; entry0 drives the outputs, entry1 absorbs overflow.
// Ports: i_valid/o_ready/i_data in, o_valid/i_ready/o_data out, flush kill.
module skid_buffer_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_v0;
  logic             r_v1;
  logic [WIDTH-1:0] r_d0;
  logic [WIDTH-1:0] r_d1;
  logic             w_push;
  logic             w_pop;

  // Ready depends only on a register, so EX stall never reaches decode.
  assign o_ready = !r_v1;
  assign o_valid = r_v0;
  assign o_data  = r_d0;
  assign w_push  = i_valid && !r_v1;
  assign w_pop   = r_v0 && i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_d0 <= '0;
      r_d1 <= '0;
    end else if (flush) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else if (r_v1) begin
      // Full: no push possible; pop shifts the overflow slot forward.
      if (w_pop) begin
        r_d0 <= r_d1;
        r_v1 <= 1'b0;
      end
    end else if (r_v0) begin
      if (w_pop && w_push) begin
        r_d0 <= i_data;
      end else if (w_pop) begin
        r_v0 <= 1'b0;
      end else if (w_push) begin
        r_d1 <= i_data;
        r_v1 <= 1'b1;
      end
    end else if (w_push) begin
      r_d0 <= i_data;
      r_v0 <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwarding, immediate extension, adder conditioning.
// Ports: decode handshake in, EX handshake out, EX/MEM and MEM/WB forwarding.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [RIDX-1:0] in_rs_idx,
  input  logic [RIDX-1:0] in_rt_idx,
  input  logic [RIDX-1:0] in_rd_idx,
  input  logic [XLEN-1:0] in_rs_val,
  input  logic [XLEN-1:0] in_rt_val,
  input  logic [15:0]     in_imm,
  input  logic            in_use_imm,
  input  logic            in_imm_zext,
  input  logic            exm_wen,
  input  logic            mwb_wen,
  input  logic [RIDX-1:0] exm_idx,
  input  logic [RIDX-1:0] mwb_idx,
  input  logic [XLEN-1:0] exm_data,
  input  logic [XLEN-1:0] mwb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic            out_cin,
  output logic [3:0]      out_op,
  output logic [RIDX-1:0] out_rd_idx,
  output logic            out_ovf_trap
);

  logic [XLEN-1:0] w_rs;
  logic [XLEN-1:0] w_rt;
  logic [XLEN-1:0] w_imm_ext;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_inv;
  logic            w_trap;
  logic [3:0]      w_op;
  opnd_t           w_in;
  opnd_t           w_q;

  assign w_rs = fwd_sel(in_rs_idx, in_rs_val,
                        exm_wen, exm_idx, exm_data,
                        mwb_wen, mwb_idx, mwb_data);
  assign w_rt = fwd_sel(in_rt_idx, in_rt_val,
                        exm_wen, exm_idx, exm_data,
                        mwb_wen, mwb_idx, mwb_data);

  assign w_imm_ext = in_imm_zext
                   ? {16'h0, in_imm}
                   : {{16{in_imm[15]}}, in_imm};

  always_comb begin
    w_inv  = 1'b0;
    w_trap = 1'b0;
    w_op   = in_op;
    unique case (in_op)
      OP_ADD: w_trap = 1'b1;
      OP_SUB: begin
        w_trap = 1'b1;
        w_inv  = 1'b1;
      end
      OP_SUBU, OP_SLT, OP_SLTU: w_inv = 1'b1;
      OP_ADDU, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_LUI: w_op = in_op;
      // Reserved codes execute as a non-trapping ADDU.
      default: w_op = OP_ADDU;
    endcase
  end

  always_comb begin
    w_a = w_rs;
    w_b = in_use_imm ? w_imm_ext : w_rt;
    if (in_op == OP_LUI) begin
      w_a = '0;
      w_b = {in_imm, 16'h0};
    end
  end

  assign w_in.a        = w_a;
  assign w_in.b        = w_inv ? ~w_b : w_b;
  assign w_in.cin      = w_inv;
  assign w_in.op       = w_op;
  assign w_in.rd       = in_rd_idx;
  assign w_in.ovf_trap = w_trap;

  skid_buffer_2 #(
    .WIDTH($bits(opnd_t))
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_q)
  );

  assign out_a        = w_q.a;
  assign out_b        = w_q.b;
  assign out_cin      = w_q.cin;
  assign out_op       = w_q.op;
  assign out_rd_idx   = w_q.rd;
  assign out_ovf_trap = w_q.ovf_trap;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed testbench for alu_operand_stage.
// Hand-computed vectors for forwarding, extension, skid and flush.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs_idx;
  logic [4:0]  in_rt_idx;
  logic [4:0]  in_rd_idx;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [15:0] in_imm;
  logic        in_use_imm;
  logic        in_imm_zext;
  logic        exm_wen;
  logic        mwb_wen;
  logic [4:0]  exm_idx;
  logic [4:0]  mwb_idx;
  logic [31:0] exm_data;
  logic [31:0] mwb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_cin;
  logic [3:0]  out_op;
  logic [4:0]  out_rd_idx;
  logic        out_ovf_trap;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rs_idx    (in_rs_idx),
    .in_rt_idx    (in_rt_idx),
    .in_rd_idx    (in_rd_idx),
    .in_rs_val    (in_rs_val),
    .in_rt_val    (in_rt_val),
    .in_imm       (in_imm),
    .in_use_imm   (in_use_imm),
    .in_imm_zext  (in_imm_zext),
    .exm_wen      (exm_wen),
    .mwb_wen      (mwb_wen),
    .exm_idx      (exm_idx),
    .mwb_idx      (mwb_idx),
    .exm_data     (exm_data),
    .mwb_data     (mwb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_cin      (out_cin),
    .out_op       (out_op),
    .out_rd_idx   (out_rd_idx),
    .out_ovf_trap (out_ovf_trap)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [3:0]  op,
                     input logic [4:0]  rs,
                     input logic [4:0]  rt,
                     input logic [4:0]  rd,
                     input logic [31:0] rsv,
                     input logic [31:0] rtv,
                     input logic [15:0] imm,
                     input logic        ui,
                     input logic        zx);
    in_valid    = 1'b1;
    in_op       = op;
    in_rs_idx   = rs;
    in_rt_idx   = rt;
    in_rd_idx   = rd;
    in_rs_val   = rsv;
    in_rt_val   = rtv;
    in_imm      = imm;
    in_use_imm  = ui;
    in_imm_zext = zx;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    exm_wen = 1'b0; mwb_wen = 1'b0;
    exm_idx = '0; mwb_idx = '0;
    exm_data = '0; mwb_data = '0;
    drv(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_a", {32'd0, out_a}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // SUB 5-3
    drv(4'd2, 5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 16'd0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("sub_valid", {63'd0, out_valid}, 64'd1);
    chk("sub_a", {32'd0, out_a}, 64'd5);
    chk("sub_b", {32'd0, out_b}, 64'hFFFFFFFC);
    chk("sub_cin", {63'd0, out_cin}, 64'd1);
    chk("sub_trap", {63'd0, out_ovf_trap}, 64'd1);
    chk("sub_rd", {59'd0, out_rd_idx}, 64'd3);
    step();
    chk("sub_pop", {63'd0, out_valid}, 64'd0);

    // ADDI sign-extended
    drv(4'd0, 5'd1, 5'd0, 5'd4, 32'd7, 32'd0, 16'h8000, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    chk("addi_b", {32'd0, out_b}, 64'hFFFF8000);
    chk("addi_cin", {63'd0, out_cin}, 64'd0);
    chk("addi_trap", {63'd0, out_ovf_trap}, 64'd1);

    // ORI zero-extended
    drv(4'd7, 5'd1, 5'd0, 5'd4, 32'd7, 32'd0, 16'h8000, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ori_b", {32'd0, out_b}, 64'h00008000);
    chk("ori_trap", {63'd0, out_ovf_trap}, 64'd0);

    // EX/MEM beats MEM/WB; MEM/WB alone on rt
    exm_wen = 1'b1; exm_idx = 5'd4; exm_data = 32'h11;
    mwb_wen = 1'b1; mwb_idx = 5'd4; mwb_data = 32'h22;
    drv(4'd1, 5'd4, 5'd4, 5'd6, 32'h99, 32'h98, 16'd0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("fwd_prio", {32'd0, out_a}, 64'h11);
    mwb_idx = 5'd5;
    drv(4'd1, 5'd9, 5'd5, 5'd6, 32'h99, 32'h98, 16'd0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("fwd_mwb", {32'd0, out_b}, 64'h22);
    chk("fwd_rf", {32'd0, out_a}, 64'h99);
    exm_idx = 5'd0; mwb_idx = 5'd0;
    drv(4'd1, 5'd0, 5'd0, 5'd6, 32'h99, 32'h98, 16'd0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("fwd_x0_a", {32'd0, out_a}, 64'd0);
    chk("fwd_x0_b", {32'd0, out_b}, 64'd0);
    exm_wen = 1'b0; mwb_wen = 1'b0;

    // LUI and reserved opcode
    drv(4'd10, 5'd1, 5'd0, 5'd2, 32'h55, 32'd0, 16'h1234, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    chk("lui_a", {32'd0, out_a}, 64'd0);
    chk("lui_b", {32'd0, out_b}, 64'h12340000);
    drv(4'd12, 5'd1, 5'd2, 5'd2, 32'h10, 32'h20, 16'd0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("ill_trap", {63'd0, out_ovf_trap}, 64'd0);
    chk("ill_b", {32'd0, out_b}, 64'h20);
    chk("ill_cin", {63'd0, out_cin}, 64'd0);
    step();

    // Skid: three pushes against a stalled EX
    out_ready = 1'b0;
    drv(4'd1, 5'd1, 5'd0, 5'd1, 32'd100, 32'd0, 16'd0, 1'b0, 1'b0);
    step();
    chk("sk1_valid", {63'd0, out_valid}, 64'd1);
    chk("sk1_ready", {63'd0, in_ready}, 64'd1);
    drv(4'd1, 5'd1, 5'd0, 5'd2, 32'd200, 32'd0, 16'd0, 1'b0, 1'b0);
    step();
    chk("sk2_ready", {63'd0, in_ready}, 64'd0);
    chk("sk2_a", {32'd0, out_a}, 64'd100);
    drv(4'd1, 5'd1, 5'd0, 5'd3, 32'd300, 32'd0, 16'd0, 1'b0, 1'b0);
    step();
    chk("sk3_ready", {63'd0, in_ready}, 64'd0);
    chk("sk3_a", {32'd0, out_a}, 64'd100);
    chk("sk3_rd", {59'd0, out_rd_idx}, 64'd1);
    out_ready = 1'b1;
    step();
    chk("dr1_a", {32'd0, out_a}, 64'd200);
    chk("dr1_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    chk("dr2_valid", {63'd0, out_valid}, 64'd1);
    chk("dr2_a", {32'd0, out_a}, 64'd300);
    step();
    chk("dr3_valid", {63'd0, out_valid}, 64'd0);

    // Flush with both entries held
    out_ready = 1'b0;
    drv(4'd1, 5'd1, 5'd0, 5'd1, 32'd111, 32'd0, 16'd0, 1'b0, 1'b0);
    step();
    drv(4'd1, 5'd1, 5'd0, 5'd2, 32'd222, 32'd0, 16'd0, 1'b0, 1'b0);
    step();
    chk("fl_full", {63'd0, in_ready}, 64'd0);
    drv(4'd1, 5'd1, 5'd0, 5'd3, 32'd333, 32'd0, 16'd0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("fl_none", {63'd0, out_valid}, 64'd0);

    // Flush with one held, input accepted that cycle is dropped
    out_ready = 1'b0;
    drv(4'd1, 5'd1, 5'd0, 5'd1, 32'd444, 32'd0, 16'd0, 1'b0, 1'b0);
    step();
    drv(4'd1, 5'd1, 5'd0, 5'd2, 32'd555, 32'd0, 16'd0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("fl1_valid", {63'd0, out_valid}, 64'd0);
    step();
    chk("fl1_none", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drv(4'd1, 5'd1, 5'd0, 5'd1, 32'd777, 32'd0, 16'd0, 1'b0, 1'b0);
    step();
    drv(4'd1, 5'd1, 5'd0, 5'd2, 32'd888, 32'd0, 16'd0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("pre_rst_a", {32'd0, out_a}, 64'd777);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_a", {32'd0, out_a}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst", {63'd0, out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
ID/EX pipeline stage directly upstream of the 32-bit carry-select adder in the EX stage. Accepts decoded instructions over a valid/ready handshake and resolves register operands through EX/MEM and MEM/WB forwarding. Extends immediates, pre-conditions the adder inputs (B inversion plus carry-in for subtract/compare), and registers everything EX consumes. Contains a 2-entry skid buffer so that EX back-pressure never creates a combinational path into decode.

Parameters:
XLEN, 32, datapath width; the adder is fixed at 32, so only 32 is legal.
RIDX, 5, register index width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
flush  in  1  branch/exception kill; drops all held and incoming entries
in_valid  in  1  decode has an instruction
in_ready  out  1  stage can accept
in_op  in  4  ALU op code (alu_pkg)
in_rs_idx, in_rt_idx, in_rd_idx  in  RIDX each  source and destination indices
in_rs_val, in_rt_val  in  XLEN each  register-file read data
in_imm  in  16  instruction immediate
in_use_imm  in  1  B comes from the immediate
in_imm_zext  in  1  zero-extend (ANDI/ORI/XORI) instead of sign-extend
exm_wen, mwb_wen  in  1 each  forwarding sources write-enable
exm_idx, mwb_idx  in  RIDX each  forwarding destination index
exm_data, mwb_data  in  XLEN each  forwarding data
out_valid  out  1  EX entry valid
out_ready  in  1  EX accepts
out_a  out  XLEN  adder/logic operand A
out_b  out  XLEN  operand B, already inverted for SUB/SUBU/SLT/SLTU
out_cin  out  1  adder carry-in
out_op  out  4  op code passed through
out_rd_idx  out  RIDX  destination
out_ovf_trap  out  1  signed-overflow trap enabled (ADD, SUB only)

Behaviour:
- Reset (async assert, sync release): out_valid=0, both skid entries empty, in_ready=1; all data outputs 0.
- Operand resolution, combinational at capture:
  - If idx==0, the value is 0, with no forwarding.
  - Else if exm_wen && exm_idx==idx, use exm_data.
  - Else if mwb_wen && mwb_idx==idx, use mwb_data.
  - Else use the register-file value.
  - EX/MEM has priority over MEM/WB.
- B select: in_use_imm chooses the immediate, zero-extended if in_imm_zext, else sign-extended; otherwise B is resolved rt.
- LUI: A=0, B={imm,16'h0}.
- Adder conditioning:
  - SUB, SUBU, SLT, SLTU: out_b = ~B, out_cin = 1.
  - All other ops: out_b = B, out_cin = 0.
- Ops and codes: ADD=0, ADDU=1, SUB=2, SUBU=3, SLT=4, SLTU=5, AND=6, OR=7, XOR=8, NOR=9, LUI=10. Codes 11-15 are illegal and are treated as ADDU with out_ovf_trap=0.
- Latency: 1 cycle from an accepted input (in_valid && in_ready) to out_valid, when the buffer is empty.
- Skid buffer:
  - Entry0 drives the outputs; entry1 is the overflow slot.
  - in_ready = !entry1_valid, registered (no combinational path from out_ready).
  - Output pops when out_valid && out_ready.
  - Simultaneous push and pop with only entry0 valid: the new data replaces entry0.
  - Pop with both entries valid: entry1 moves to entry0.
  - Push when entry0 is valid and not popping: the data goes to entry1.
- Data held in the skid keeps the operands resolved at capture; re-forwarding is not performed. The hazard unit guarantees held entries are not stale.
- out_* are stable while out_valid && !out_ready.
- flush: next cycle both entries are invalid, the input that cycle is discarded, and in_ready=1. flush has priority over push and pop.
- rst mid-operation: all entries are lost immediately.

Decomposition:
- alu_pkg: op-code localparams, XLEN/RIDX defaults, and an operand-bundle struct {a, b, cin, op, rd, ovf_trap}.
- Sub-module skid_buffer_2 (parameter WIDTH) holds the bundle; the top contains forwarding, extension and conditioning logic.

Test Plan:
- rst=1 mid-stream → out_valid=0, in_ready=1 asynchronously, out_a=0.
- SUB with rs_val=5, rt_val=3, out_ready=1 → next cycle out_a=5, out_b=32'hFFFFFFFC, out_cin=1, out_ovf_trap=1.
- ADDI imm=16'h8000 signed → out_b=32'hFFFF8000. ORI imm=16'h8000 zext → out_b=32'h00008000.
- rs_idx=4, exm_wen with exm_idx=4 data 0x11, mwb_wen with mwb_idx=4 data 0x22 → out_a=0x11. rs_idx=0 with both forwarding sources matching 0 → out_a=0.
- Hold out_ready=0 and push 3 instructions → in_ready falls after the 2nd. Outputs stay at the 1st. Release → 1st, 2nd, 3rd drain in order with no loss or duplication.
- Two entries held, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle input is never emitted.
